// File: rtl/pic_exec_sequencer_pkg.sv
// Shared types for the PIC16 execute sequencer: ALU op codes, instruction
// classes, sequencer states and the instruction decoder.
package pic_exec_sequencer_pkg;

    localparam int ALU_OP_W = 4;
    localparam logic [13:0] OPC_RETURN = 14'h0008;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_CLR  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_IOR  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_MOVB = 4'd6,   // pass operand B (f or k)
        ALU_MOVW = 4'd7,   // pass W
        ALU_COM  = 4'd8,
        ALU_INC  = 4'd9,
        ALU_DEC  = 4'd10,
        ALU_RR   = 4'd11,
        ALU_RL   = 4'd12,
        ALU_SWAP = 4'd13,
        ALU_BCF  = 4'd14,
        ALU_BSF  = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_BYTE,
        CLS_SKIPZ,
        CLS_LIT,
        CLS_BITSET,
        CLS_BTFSC,
        CLS_BTFSS,
        CLS_GOTO,
        CLS_CALL,
        CLS_RETURN,
        CLS_RETLW
    } instr_class_e;

    typedef enum logic {
        ST_EXEC  = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_e;

    typedef struct packed {
        instr_class_e cls;
        alu_op_e      op;
        logic         status_wr;
    } dec_t;

    function automatic dec_t decode_instr(input logic [13:0] ir);
        dec_t d;
        d.cls       = CLS_NOP;
        d.op        = ALU_CLR;
        d.status_wr = 1'b0;
        case (ir[13:12])
            2'b00: begin
                if (ir[11:8] == 4'h0) begin
                    // MOVWF, RETURN; the rest of this corner (NOP, SLEEP, ...) idles
                    if (ir[7]) begin
                        d.cls = CLS_BYTE;
                        d.op  = ALU_MOVW;
                    end else if (ir == OPC_RETURN) begin
                        d.cls = CLS_RETURN;
                    end
                end else begin
                    d.cls       = CLS_BYTE;
                    d.status_wr = 1'b1;
                    case (ir[11:8])
                        4'h1: d.op = ALU_CLR;
                        4'h2: d.op = ALU_SUB;
                        4'h3: d.op = ALU_DEC;
                        4'h4: d.op = ALU_IOR;
                        4'h5: d.op = ALU_AND;
                        4'h6: d.op = ALU_XOR;
                        4'h7: d.op = ALU_ADD;
                        4'h8: d.op = ALU_MOVB;
                        4'h9: d.op = ALU_COM;
                        4'hA: d.op = ALU_INC;
                        4'hB: begin
                            d.op  = ALU_DEC;
                            d.cls = CLS_SKIPZ;
                        end
                        4'hC: d.op = ALU_RR;
                        4'hD: d.op = ALU_RL;
                        4'hE: begin
                            d.op        = ALU_SWAP;
                            d.status_wr = 1'b0;
                        end
                        default: begin
                            d.op  = ALU_INC;
                            d.cls = CLS_SKIPZ;
                        end
                    endcase
                end
            end
            2'b01: begin
                case (ir[11:10])
                    2'b00: begin
                        d.cls = CLS_BITSET;
                        d.op  = ALU_BCF;
                    end
                    2'b01: begin
                        d.cls = CLS_BITSET;
                        d.op  = ALU_BSF;
                    end
                    2'b10:   d.cls = CLS_BTFSC;
                    default: d.cls = CLS_BTFSS;
                endcase
            end
            2'b10: d.cls = ir[11] ? CLS_GOTO : CLS_CALL;
            default: begin
                d.cls       = CLS_LIT;
                d.status_wr = 1'b1;
                casez (ir[11:8])
                    4'b00??: begin
                        d.op        = ALU_MOVB;
                        d.status_wr = 1'b0;
                    end
                    4'b01??: begin
                        d.op        = ALU_MOVB;
                        d.status_wr = 1'b0;
                        d.cls       = CLS_RETLW;
                    end
                    4'b1000: d.op = ALU_IOR;
                    4'b1001: d.op = ALU_AND;
                    4'b1010: d.op = ALU_XOR;
                    4'b110?: d.op = ALU_SUB;
                    default: d.op = ALU_ADD;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pic_exec_sequencer_if.sv
// Bundle between the sequencer and the IR / ALU / PC / fetch datapath.
interface pic_exec_sequencer_if #(
    parameter int PC_WIDTH = 13
);
    import pic_exec_sequencer_pkg::*;

    logic [13:0]          instr_current;
    logic [PC_WIDTH-1:0]  pc_current;
    logic                 status_z;
    logic                 bit_test;
    logic [1:0]           q_count;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_sel_l;
    logic                 alu_d;
    logic [2:0]           alu_bit;
    logic                 alu_d_wr_en;
    logic                 alu_status_wr_en;
    logic                 instr_rd_en;
    logic                 instr_flush;
    logic                 pc_incr_en;
    logic                 pc_j_en;
    logic                 pc_load_en;
    logic [PC_WIDTH-1:0]  pc_load_val;
    logic                 stack_overflow;
    logic                 stack_underflow;

    modport master (
        input  instr_current, pc_current, status_z, bit_test,
        output q_count, alu_op, alu_sel_l, alu_d, alu_bit, alu_d_wr_en,
               alu_status_wr_en, instr_rd_en, instr_flush, pc_incr_en,
               pc_j_en, pc_load_en, pc_load_val, stack_overflow, stack_underflow
    );

    modport slave (
        output instr_current, pc_current, status_z, bit_test,
        input  q_count, alu_op, alu_sel_l, alu_d, alu_bit, alu_d_wr_en,
               alu_status_wr_en, instr_rd_en, instr_flush, pc_incr_en,
               pc_j_en, pc_load_en, pc_load_val, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/pic_exec_sequencer_return_stack.sv
// Circular hardware return stack with occupancy count and sticky
// overflow/underflow flags; WRAP selects overwrite-oldest vs drop on full.
module pic_return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pic_return_stack: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic             wr_en;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    // When full, wr_ptr already points at the oldest entry, so wrapping overwrites it.
    assign wr_en = push && (!full || WRAP != 0);
    assign top   = mem[wr_ptr_reg - PW'(1)];
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (push && !full) begin
                count_reg <= count_reg + (PW + 1)'(1);
            end
            if (push && full) begin
                ovf_reg <= 1'b1;
            end
            if (pop) begin
                if (empty) begin
                    unf_reg <= 1'b1;
                end else begin
                    wr_ptr_reg <= wr_ptr_reg - PW'(1);
                    count_reg  <= count_reg - (PW + 1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pic_exec_sequencer.sv
// PIC16 execute sequencer: Q0..Q3 phase counter, EXEC/FLUSH state and the
// per-phase control strobes for ALU, PC, fetch and the return stack.
module pic_exec_sequencer
    import pic_exec_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = 13,
    parameter int STACK_DEPTH = 8,
    parameter int STACK_WRAP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pic_exec_sequencer_if.master bus
);
    seq_state_e          state_reg;
    seq_state_e          state_next;
    logic [1:0]          q_count_reg;
    dec_t                dec;
    logic                skip_taken;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] stk_top;
    logic                stk_full;
    logic                stk_empty;
    logic                stk_ovf;
    logic                stk_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_count_reg <= 2'd0;
            state_reg   <= ST_EXEC;
        end else begin
            q_count_reg <= q_count_reg + 2'd1;
            state_reg   <= state_next;
        end
    end

    assign dec = decode_instr(bus.instr_current);

    always_comb begin
        case (dec.cls)
            CLS_SKIPZ: skip_taken = bus.status_z;
            CLS_BTFSC: skip_taken = !bus.bit_test;
            CLS_BTFSS: skip_taken = bus.bit_test;
            default:   skip_taken = 1'b0;
        endcase
    end

    // Strobes are held low while rst is high so an aborted instruction leaves no side effects.
    always_comb begin
        state_next           = state_reg;
        bus.alu_op           = ALU_CLR;
        bus.alu_sel_l        = 1'b0;
        bus.alu_d            = bus.instr_current[7];
        bus.alu_bit          = bus.instr_current[9:7];
        bus.alu_d_wr_en      = 1'b0;
        bus.alu_status_wr_en = 1'b0;
        bus.instr_rd_en      = 1'b0;
        bus.instr_flush      = 1'b0;
        bus.pc_incr_en       = 1'b0;
        bus.pc_j_en          = 1'b0;
        bus.pc_load_en       = 1'b0;
        push                 = 1'b0;
        pop                  = 1'b0;
        if (!rst) begin
            if (state_reg == ST_EXEC) begin
                if (q_count_reg == 2'd2) begin
                    case (dec.cls)
                        CLS_BYTE, CLS_SKIPZ: begin
                            bus.alu_op           = dec.op;
                            bus.alu_d_wr_en      = 1'b1;
                            bus.alu_status_wr_en = dec.status_wr;
                        end
                        CLS_LIT, CLS_RETLW: begin
                            bus.alu_op           = dec.op;
                            bus.alu_sel_l        = 1'b1;
                            bus.alu_d            = 1'b0;
                            bus.alu_d_wr_en      = 1'b1;
                            bus.alu_status_wr_en = dec.status_wr;
                        end
                        CLS_BITSET: begin
                            bus.alu_op      = dec.op;
                            bus.alu_d       = 1'b1;
                            bus.alu_d_wr_en = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (q_count_reg == 2'd3) begin
                    case (dec.cls)
                        CLS_GOTO, CLS_CALL: begin
                            push            = (dec.cls == CLS_CALL);
                            bus.pc_j_en     = 1'b1;
                            bus.instr_flush = 1'b1;
                            state_next      = ST_FLUSH;
                        end
                        CLS_RETURN, CLS_RETLW: begin
                            pop             = 1'b1;
                            bus.pc_load_en  = 1'b1;
                            bus.instr_flush = 1'b1;
                            state_next      = ST_FLUSH;
                        end
                        default: begin
                            if (skip_taken) begin
                                // Skipped word: advance PC past it but discard the prefetch.
                                bus.instr_flush = 1'b1;
                                bus.pc_incr_en  = 1'b1;
                                state_next      = ST_FLUSH;
                            end else begin
                                bus.instr_rd_en = 1'b1;
                                bus.pc_incr_en  = 1'b1;
                            end
                        end
                    endcase
                end
            end else if (q_count_reg == 2'd3) begin
                bus.instr_rd_en = 1'b1;
                bus.pc_incr_en  = 1'b1;
                state_next      = ST_EXEC;
            end
        end
    end

    pic_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH),
        .WRAP  (STACK_WRAP)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.pc_current + PC_WIDTH'(1)),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .ovf   (stk_ovf),
        .unf   (stk_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(stk_full && stk_empty));
        end
    end

    assign bus.q_count         = q_count_reg;
    assign bus.pc_load_val     = stk_empty ? '0 : stk_top;
    assign bus.stack_overflow  = stk_ovf;
    assign bus.stack_underflow = stk_unf;

endmodule

// File: tb/tb_pic_exec_sequencer.sv
// Randomised bench for pic_exec_sequencer against a table-driven instruction
// model with a queue-based return stack.
module tb_pic_exec_sequencer;
    import pic_exec_sequencer_pkg::*;

    localparam int PCW   = 13;
    localparam int DEPTH = 8;

    localparam int K_NOP = 0, K_BYTE = 1, K_SKZ = 2, K_LIT = 3, K_BIT = 4, K_BTFSC = 5;
    localparam int K_BTFSS = 6, K_GOTO = 7, K_CALL = 8, K_RET = 9, K_RETLW = 10;

    typedef struct {
        logic [13:0] mask;
        logic [13:0] val;
        int          kind;
        logic [3:0]  op;
        bit          st;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    ent_t             tbl[$];
    logic [PCW-1:0]   stk_q[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    pic_exec_sequencer_if #(.PC_WIDTH(PCW)) bus ();

    pic_exec_sequencer #(
        .PC_WIDTH    (PCW),
        .STACK_DEPTH (DEPTH),
        .STACK_WRAP  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [13:0] mask, input logic [13:0] val, input int kind,
                       input logic [3:0] op, input bit st);
        tbl.push_back('{mask, val, kind, op, st});
    endtask

    // Mid-range PIC16 opcode map; first matching row wins.
    task automatic build_table();
        add(14'h3FFF, 14'h0008, K_RET,   ALU_CLR,  0);
        add(14'h3F80, 14'h0080, K_BYTE,  ALU_MOVW, 0);
        add(14'h3F80, 14'h0000, K_NOP,   ALU_CLR,  0);
        add(14'h3F00, 14'h0100, K_BYTE,  ALU_CLR,  1);
        add(14'h3F00, 14'h0200, K_BYTE,  ALU_SUB,  1);
        add(14'h3F00, 14'h0300, K_BYTE,  ALU_DEC,  1);
        add(14'h3F00, 14'h0400, K_BYTE,  ALU_IOR,  1);
        add(14'h3F00, 14'h0500, K_BYTE,  ALU_AND,  1);
        add(14'h3F00, 14'h0600, K_BYTE,  ALU_XOR,  1);
        add(14'h3F00, 14'h0700, K_BYTE,  ALU_ADD,  1);
        add(14'h3F00, 14'h0800, K_BYTE,  ALU_MOVB, 1);
        add(14'h3F00, 14'h0900, K_BYTE,  ALU_COM,  1);
        add(14'h3F00, 14'h0A00, K_BYTE,  ALU_INC,  1);
        add(14'h3F00, 14'h0B00, K_SKZ,   ALU_DEC,  1);
        add(14'h3F00, 14'h0C00, K_BYTE,  ALU_RR,   1);
        add(14'h3F00, 14'h0D00, K_BYTE,  ALU_RL,   1);
        add(14'h3F00, 14'h0E00, K_BYTE,  ALU_SWAP, 0);
        add(14'h3F00, 14'h0F00, K_SKZ,   ALU_INC,  1);
        add(14'h3C00, 14'h1000, K_BIT,   ALU_BCF,  0);
        add(14'h3C00, 14'h1400, K_BIT,   ALU_BSF,  0);
        add(14'h3C00, 14'h1800, K_BTFSC, ALU_CLR,  0);
        add(14'h3C00, 14'h1C00, K_BTFSS, ALU_CLR,  0);
        add(14'h3800, 14'h2000, K_CALL,  ALU_CLR,  0);
        add(14'h3800, 14'h2800, K_GOTO,  ALU_CLR,  0);
        add(14'h3C00, 14'h3000, K_LIT,   ALU_MOVB, 0);
        add(14'h3C00, 14'h3400, K_RETLW, ALU_MOVB, 0);
        add(14'h3F00, 14'h3800, K_LIT,   ALU_IOR,  1);
        add(14'h3F00, 14'h3900, K_LIT,   ALU_AND,  1);
        add(14'h3F00, 14'h3A00, K_LIT,   ALU_XOR,  1);
        add(14'h3E00, 14'h3C00, K_LIT,   ALU_SUB,  1);
        add(14'h3E00, 14'h3E00, K_LIT,   ALU_ADD,  1);
    endtask

    task automatic classify(input logic [13:0] ins, output int kind, output logic [3:0] op,
                            output bit st);
        kind = K_NOP;
        op   = ALU_CLR;
        st   = 1'b0;
        for (int i = tbl.size() - 1; i >= 0; i--) begin
            if ((ins & tbl[i].mask) == tbl[i].val) begin
                kind = tbl[i].kind;
                op   = tbl[i].op;
                st   = tbl[i].st;
            end
        end
    endtask

    task automatic model_clear();
        stk_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_current = '0;
        bus.pc_current    = '0;
        bus.status_z      = 1'b0;
        bus.bit_test      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Run one instruction (4 or 8 clocks), comparing every cycle; max_cyc truncates.
    task automatic run_instr(input logic [13:0] ins, input logic [PCW-1:0] pc, input bit z,
                             input bit bt, input int max_cyc);
        int          kind;
        logic [3:0]  op;
        bit          st;
        bit          taken;
        bit          two;
        bit          wr;
        bit          lit;
        int          len;
        int          ph;
        bit          fl;
        logic [13:0] cur;
        logic [7:0]  exp_s;
        logic [7:0]  got_s;
        logic        exp_d;
        logic [PCW-1:0] exp_plv;
        classify(ins, kind, op, st);
        taken = (kind == K_SKZ && z) || (kind == K_BTFSC && !bt) || (kind == K_BTFSS && bt);
        two   = taken || kind == K_GOTO || kind == K_CALL || kind == K_RET || kind == K_RETLW;
        wr    = kind == K_BYTE || kind == K_SKZ || kind == K_LIT || kind == K_BIT || kind == K_RETLW;
        lit   = kind == K_LIT || kind == K_RETLW;
        len   = two ? 8 : 4;
        if (max_cyc < len) len = max_cyc;
        txn++;
        $display("txn %0d instr %04h pc %04h z %0b bt %0b kind %0d cycles %0d stack %0d",
                 txn, ins, pc, z, bt, kind, len, stk_q.size());
        bus.instr_current = ins;
        bus.pc_current    = pc;
        bus.status_z      = z;
        bus.bit_test      = bt;
        for (int c = 0; c < len; c++) begin
            if (c == 4) bus.instr_current = '0;
            fl    = (c >= 4);
            ph    = c % 4;
            cur   = fl ? 14'h0000 : ins;
            exp_s = '0;
            exp_d = cur[7];
            if (!fl && ph == 2 && wr) begin
                exp_s[7] = 1'b1;
                exp_s[6] = st;
                exp_s[5] = lit;
                if (lit) exp_d = 1'b0;
                else if (kind == K_BIT) exp_d = 1'b1;
            end
            if (ph == 3) begin
                if (fl || !two) begin
                    exp_s[4] = 1'b1;
                    exp_s[2] = 1'b1;
                end else begin
                    exp_s[3] = 1'b1;
                    exp_s[2] = taken;
                    exp_s[1] = (kind == K_GOTO || kind == K_CALL);
                    exp_s[0] = (kind == K_RET || kind == K_RETLW);
                end
            end
            exp_plv = (stk_q.size() == 0) ? '0 : stk_q[$];
            @(negedge clk);
            got_s = {bus.alu_d_wr_en, bus.alu_status_wr_en, bus.alu_sel_l, bus.instr_rd_en,
                     bus.instr_flush, bus.pc_incr_en, bus.pc_j_en, bus.pc_load_en};
            check($sformatf("q_count t%0d c%0d", txn, c), 32'(bus.q_count), 32'(ph));
            check($sformatf("strobes t%0d c%0d", txn, c), 32'(got_s), 32'(exp_s));
            check($sformatf("alu_d t%0d c%0d", txn, c), 32'(bus.alu_d), 32'(exp_d));
            check($sformatf("alu_bit t%0d c%0d", txn, c), 32'(bus.alu_bit), 32'(cur[9:7]));
            check($sformatf("pc_load_val t%0d c%0d", txn, c), 32'(bus.pc_load_val), 32'(exp_plv));
            check($sformatf("flags t%0d c%0d", txn, c),
                  32'({bus.stack_overflow, bus.stack_underflow}), 32'({m_ovf, m_unf}));
            if (exp_s[7]) check($sformatf("alu_op t%0d c%0d", txn, c), 32'(bus.alu_op), 32'(op));
            @(posedge clk);
            #1;
            if (c == 3) begin
                if (kind == K_CALL) begin
                    if (stk_q.size() == DEPTH) begin
                        m_ovf = 1'b1;
                        void'(stk_q.pop_front());
                    end
                    stk_q.push_back(PCW'(pc + 1));
                end else if (kind == K_RET || kind == K_RETLW) begin
                    if (stk_q.size() == 0) m_unf = 1'b1;
                    else void'(stk_q.pop_back());
                end
            end
        end
    endtask

    initial begin
        int          idx;
        logic [13:0] ins;
        logic [PCW-1:0] pc;
        build_table();
        do_reset();

        for (int i = 0; i < 6; i++) run_instr(14'h0000, PCW'(i), 1'b0, 1'b0, 8);
        run_instr(14'h2800 | 14'h0123, 13'h0040, 1'b0, 1'b0, 8);
        run_instr(14'h2000 | 14'h0200, 13'h0010, 1'b0, 1'b0, 8);
        run_instr(14'h0008, 13'h0200, 1'b0, 1'b0, 8);
        run_instr(14'h0B00 | 14'h00A5, 13'h0011, 1'b1, 1'b0, 8);
        run_instr(14'h0B00 | 14'h00A5, 13'h0013, 1'b0, 1'b0, 8);
        run_instr(14'h3E05, 13'h0014, 1'b0, 1'b0, 8);
        run_instr(14'h1400 | (14'd3 << 7) | 14'h0021, 13'h0015, 1'b0, 1'b0, 8);
        run_instr(14'h1800 | 14'h0021, 13'h0016, 1'b0, 1'b0, 8);
        run_instr(14'h1800 | 14'h0021, 13'h0017, 1'b0, 1'b1, 8);
        run_instr(14'h1C00 | 14'h0021, 13'h0018, 1'b0, 1'b1, 8);
        run_instr(14'h3455, 13'h0019, 1'b0, 1'b0, 8);

        do_reset();
        for (int i = 0; i < 9; i++) run_instr(14'h2000 | 14'(i), PCW'(13'h0100 + i), 1'b0, 1'b0, 8);
        for (int i = 0; i < 9; i++) run_instr(14'h0008, 13'h0000, 1'b0, 1'b0, 8);

        do_reset();
        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, tbl.size() - 1);
            ins = tbl[idx].val | (14'($urandom) & ~tbl[idx].mask);
            pc  = ($urandom_range(0, 7) == 0) ? {PCW{1'b1}} : PCW'($urandom);
            run_instr(ins, pc, 1'($urandom), 1'($urandom), 8);
        end

        // Abort a GOTO during FLUSH Q1 with the stack non-empty.
        run_instr(14'h2000, 13'h0300, 1'b0, 1'b0, 8);
        run_instr(14'h2800 | 14'h0123, 13'h0301, 1'b0, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle q_count", 32'(bus.q_count), 32'd1);
        check("rst_cycle strobes",
              32'({bus.alu_d_wr_en, bus.alu_status_wr_en, bus.instr_rd_en, bus.instr_flush,
                   bus.pc_incr_en, bus.pc_j_en, bus.pc_load_en}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        run_instr(14'h0000, 13'h0000, 1'b0, 1'b0, 8);
        run_instr(14'h0008, 13'h0001, 1'b0, 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
